// File: rtl/des_block_loader_if.sv
// rtl/des_block_loader_if.sv - byte stream in, assembled DES block out, between loader and its neighbours
interface des_block_loader_if;
  logic [8:1]  din;
  logic        din_valid;
  logic        din_ready;
  logic        abort;
  logic        blk_ack;
  logic [64:1] plaintxt;
  logic        select;
  logic        blk_valid;
  logic [3:0]  byte_cnt;

  modport master (
    output din, din_valid, abort, blk_ack,
    input  din_ready, plaintxt, select, blk_valid, byte_cnt
  );

  modport slave (
    input  din, din_valid, abort, blk_ack,
    output din_ready, plaintxt, select, blk_valid, byte_cnt
  );
endinterface

// File: rtl/des_block_loader.sv
// rtl/des_block_loader.sv - assembles 8 input bytes into a 64-bit block and holds it for the IP stage
module des_block_loader #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst_n,
  des_block_loader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, SETUP, HOLD} state_t;

  state_t      state;
  logic [63:0] buffer;
  logic [3:0]  cnt;
  logic [63:0] plaintxt_q;
  logic        select_q;

  logic        din_ready;
  logic        accept;
  logic [3:0]  next_cnt;
  logic [2:0]  slot;
  logic [63:0] buffer_wr;

  always_comb begin
    din_ready = 1'b0;
    if (rst_n && state != SETUP && cnt < 4'd8) begin
      din_ready = 1'b1;
    end
  end

  assign accept   = bus.din_valid && din_ready;
  assign next_cnt = cnt + {3'b000, accept};
  // Slot 0 is the top byte when MSB_FIRST, so the byte index is 7 - cnt
  assign slot     = MSB_FIRST ? ~cnt[2:0] : cnt[2:0];

  always_comb begin
    buffer_wr = buffer;
    if (accept) begin
      buffer_wr[{slot, 3'b000} +: 8] = bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      buffer     <= '0;
      cnt        <= '0;
      plaintxt_q <= '0;
      select_q   <= 1'b0;
    end else if (bus.abort) begin
      state    <= IDLE;
      buffer   <= '0;
      cnt      <= '0;
      select_q <= 1'b0;
    end else begin
      if (accept) begin
        buffer <= buffer_wr;
        cnt    <= next_cnt;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          if (next_cnt == 4'd8) begin
            state <= SETUP;
          end
        end
        SETUP: begin
          plaintxt_q <= buffer;
          buffer     <= '0;
          cnt        <= '0;
          state      <= HOLD;
        end
        HOLD: begin
          // select rises one edge after plaintxt loads; an ack only answers a presented block
          if (bus.blk_ack && select_q) begin
            select_q <= 1'b0;
            if (next_cnt == 4'd8) begin
              state <= SETUP;
            end else if (next_cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              state <= LOAD;
            end
          end else begin
            select_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.din_ready = din_ready;
  assign bus.plaintxt  = plaintxt_q;
  assign bus.select    = select_q;
  assign bus.blk_valid = select_q;
  assign bus.byte_cnt  = cnt;

endmodule

// File: tb/tb_des_block_loader.sv
// tb/tb_des_block_loader.sv - directed bench for des_block_loader in both byte orders
module tb_des_block_loader;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  des_block_loader_if m ();
  des_block_loader_if l ();

  des_block_loader #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst_n(rst_n), .bus(m));
  des_block_loader #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst_n(rst_n), .bus(l));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] blk, input int n);
    for (int i = 0; i < n; i++) begin
      m.din       = blk[63 - 8*i -: 8];
      m.din_valid = 1'b1;
      step();
    end
    m.din_valid = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    m.din       = '0;
    m.din_valid = 1'b0;
    m.abort     = 1'b0;
    m.blk_ack   = 1'b0;
    l.din       = '0;
    l.din_valid = 1'b0;
    l.abort     = 1'b0;
    l.blk_ack   = 1'b0;
    step();
    step();
    chk("rst_plaintxt", m.plaintxt, 64'h0);
    chk("rst_select", {63'b0, m.select}, 64'd0);
    chk("rst_blk_valid", {63'b0, m.blk_valid}, 64'd0);
    chk("rst_byte_cnt", {60'b0, m.byte_cnt}, 64'd0);
    chk("rst_din_ready", {63'b0, m.din_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_din_ready", {63'b0, m.din_ready}, 64'd1);

    // first block: 8th accept at edge N, plaintxt at N+1, select at N+2
    send(64'h0123456789ABCDEF, 8);
    chk("b1_setup_din_ready", {63'b0, m.din_ready}, 64'd0);
    chk("b1_setup_select", {63'b0, m.select}, 64'd0);
    step();
    chk("b1_plaintxt", m.plaintxt, 64'h0123456789ABCDEF);
    chk("b1_select_low", {63'b0, m.select}, 64'd0);
    chk("b1_cnt_cleared", {60'b0, m.byte_cnt}, 64'd0);
    step();
    chk("b1_select", {63'b0, m.select}, 64'd1);
    chk("b1_blk_valid", {63'b0, m.blk_valid}, 64'd1);

    // preload a full second block while held
    send(64'h1122334455667788, 8);
    chk("b2_preload_cnt", {60'b0, m.byte_cnt}, 64'd8);
    chk("b2_preload_ready", {63'b0, m.din_ready}, 64'd0);
    m.din       = 8'h99;
    m.din_valid = 1'b1;
    step();
    m.din_valid = 1'b0;
    chk("b2_ignored_byte_cnt", {60'b0, m.byte_cnt}, 64'd8);
    for (int i = 0; i < 10; i++) step();
    chk("b2_hold_plaintxt", m.plaintxt, 64'h0123456789ABCDEF);
    chk("b2_hold_select", {63'b0, m.select}, 64'd1);
    m.blk_ack = 1'b1;
    step();
    m.blk_ack = 1'b0;
    chk("b2_ack_select", {63'b0, m.select}, 64'd0);
    chk("b2_ack_blk_valid", {63'b0, m.blk_valid}, 64'd0);
    chk("b2_setup_ready", {63'b0, m.din_ready}, 64'd0);
    step();
    chk("b2_plaintxt", m.plaintxt, 64'h1122334455667788);
    chk("b2_select_low", {63'b0, m.select}, 64'd0);
    step();
    chk("b2_select", {63'b0, m.select}, 64'd1);

    // abort with a 6th byte on the same edge
    send(64'hC1C2C3C4C5000000, 5);
    chk("ab_cnt5", {60'b0, m.byte_cnt}, 64'd5);
    m.din       = 8'h66;
    m.din_valid = 1'b1;
    m.abort     = 1'b1;
    step();
    m.din_valid = 1'b0;
    m.abort     = 1'b0;
    chk("ab_cnt", {60'b0, m.byte_cnt}, 64'd0);
    chk("ab_select", {63'b0, m.select}, 64'd0);
    chk("ab_blk_valid", {63'b0, m.blk_valid}, 64'd0);
    chk("ab_plaintxt_kept", m.plaintxt, 64'h1122334455667788);
    chk("ab_idle_ready", {63'b0, m.din_ready}, 64'd1);
    send(64'hA0A1A2A3A4A5A6A7, 8);
    step();
    chk("ab_clean_block", m.plaintxt, 64'hA0A1A2A3A4A5A6A7);
    step();
    chk("ab_clean_select", {63'b0, m.select}, 64'd1);

    // ack together with the 8th preloaded byte goes straight to SETUP
    send(64'hB0B1B2B3B4B5B600, 7);
    chk("sim_cnt7", {60'b0, m.byte_cnt}, 64'd7);
    m.din       = 8'hB7;
    m.din_valid = 1'b1;
    m.blk_ack   = 1'b1;
    step();
    m.din_valid = 1'b0;
    m.blk_ack   = 1'b0;
    chk("sim_cnt8", {60'b0, m.byte_cnt}, 64'd8);
    chk("sim_select", {63'b0, m.select}, 64'd0);
    chk("sim_setup_ready", {63'b0, m.din_ready}, 64'd0);
    step();
    chk("sim_plaintxt", m.plaintxt, 64'hB0B1B2B3B4B5B6B7);
    step();
    chk("sim_select_up", {63'b0, m.select}, 64'd1);

    // reset mid-LOAD
    m.blk_ack = 1'b1;
    step();
    m.blk_ack = 1'b0;
    chk("rl_idle_cnt", {60'b0, m.byte_cnt}, 64'd0);
    chk("rl_idle_select", {63'b0, m.select}, 64'd0);
    send(64'hD0D1D2D3_00000000, 4);
    chk("rl_cnt4", {60'b0, m.byte_cnt}, 64'd4);
    rst_n       = 1'b0;
    m.din       = 8'h55;
    m.din_valid = 1'b1;
    #1;
    chk("rl_din_ready_low", {63'b0, m.din_ready}, 64'd0);
    step();
    m.din_valid = 1'b0;
    rst_n       = 1'b1;
    chk("rl_cnt", {60'b0, m.byte_cnt}, 64'd0);
    chk("rl_plaintxt", m.plaintxt, 64'h0);
    chk("rl_select", {63'b0, m.select}, 64'd0);
    m.blk_ack = 1'b1;
    step();
    m.blk_ack = 1'b0;
    chk("spur_ack_select", {63'b0, m.select}, 64'd0);
    chk("spur_ack_cnt", {60'b0, m.byte_cnt}, 64'd0);
    chk("spur_ack_ready", {63'b0, m.din_ready}, 64'd1);

    // reset mid-HOLD
    send(64'hE0E1E2E3E4E5E6E7, 8);
    step();
    step();
    chk("rh_select_up", {63'b0, m.select}, 64'd1);
    chk("rh_plaintxt", m.plaintxt, 64'hE0E1E2E3E4E5E6E7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rh_select", {63'b0, m.select}, 64'd0);
    chk("rh_blk_valid", {63'b0, m.blk_valid}, 64'd0);
    chk("rh_plaintxt_rst", m.plaintxt, 64'h0);

    // reversed byte order
    for (int i = 1; i <= 8; i++) begin
      l.din       = 8'(i);
      l.din_valid = 1'b1;
      step();
    end
    l.din_valid = 1'b0;
    step();
    chk("lsb_plaintxt", l.plaintxt, 64'h0807060504030201);
    step();
    chk("lsb_select", {63'b0, l.select}, 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
